// File: rtl/ltc2324_capture_if.sv
// Control and sample-stream bundle between the LTC2324 capture block and its
// neighbours (software start/ack handshake plus the 64-bit word stream).
interface ltc2324_capture_if;
  logic [31:0] sample_len;
  logic        sample_start;
  logic        st_clr;
  logic [63:0] data;
  logic        data_valid;
  logic        data_last;
  logic        busy;

  modport master (
    input  sample_len, sample_start,
    output st_clr, data, data_valid, data_last, busy
  );

  modport slave (
    output sample_len, sample_start,
    input  st_clr, data, data_valid, data_last, busy
  );
endinterface

// File: rtl/ltc2324_capture.sv
// Burst conversion sequencer and four-lane serial receiver for the LTC2324-16:
// drives CNV/SCK and emits one {ch1,ch2,ch3,ch4} word per conversion.
module ltc2324_capture #(
  parameter int CNV_HIGH_CYCLES  = 4,
  parameter int CONV_WAIT_CYCLES = 45,
  parameter int SAMPLE_PERIOD    = 100,
  parameter bit TEST_MODE        = 1'b0
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  ltc2324_capture_if.master ctl,
  output logic              adc_CNV,
  output logic              adc_SCK,
  input  logic              adc_SDO1,
  input  logic              adc_SDO2,
  input  logic              adc_SDO3,
  input  logic              adc_SDO4
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] CNV_LAST    = TW'(CNV_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(CNV_HIGH_CYCLES + CONV_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAIT,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t      state_reg;
  logic [TW-1:0] t_reg;
  logic [4:0]  k_reg;
  logic [31:0] len_reg;
  logic [31:0] conv_reg;
  logic [15:0] ramp_reg;
  logic        cnv_reg;
  logic        sck_reg;
  logic        st_clr_reg;
  logic [63:0] data_reg;
  logic        valid_reg;
  logic        last_reg;
  logic        busy_reg;

  logic [3:0]       sdo;
  logic [3:0][15:0] ch_next;
  logic [63:0]      data_next;
  logic             shift_en;

  assign sdo = {adc_SDO4, adc_SDO3, adc_SDO2, adc_SDO1};

  // Lanes are captured at the end of each SCK-low half, i.e. on odd k.
  assign shift_en = (state_reg == S_SHIFT) && k_reg[0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [14:0] sh_reg;

      assign ch_next[gi] = {sh_reg, sdo[gi]};

      always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
          sh_reg <= '0;
        end else if (shift_en) begin
          sh_reg <= ch_next[gi][14:0];
        end
      end
    end
  endgenerate

  // ch_next already holds the final bit on the edge that closes k=31.
  assign data_next = TEST_MODE ? {4{ramp_reg}}
                               : {ch_next[0], ch_next[1], ch_next[2], ch_next[3]};

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_reg  <= S_IDLE;
      t_reg      <= '0;
      k_reg      <= '0;
      len_reg    <= '0;
      conv_reg   <= '0;
      ramp_reg   <= '0;
      cnv_reg    <= 1'b0;
      sck_reg    <= 1'b0;
      st_clr_reg <= 1'b0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      st_clr_reg <= 1'b0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (ctl.sample_start) begin
            st_clr_reg <= 1'b1;
            len_reg    <= ctl.sample_len;
            ramp_reg   <= '0;
            if (ctl.sample_len != '0) begin
              state_reg <= S_CNV;
              t_reg     <= '0;
              conv_reg  <= 32'd1;
              cnv_reg   <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
        end

        S_CNV: begin
          t_reg <= t_reg + 1'b1;
          if (t_reg == CNV_LAST) begin
            cnv_reg   <= 1'b0;
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          t_reg <= t_reg + 1'b1;
          if (t_reg == WAIT_LAST) begin
            sck_reg   <= 1'b1;
            k_reg     <= '0;
            state_reg <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          t_reg <= t_reg + 1'b1;
          k_reg <= k_reg + 5'd1;
          if (k_reg == 5'd31) begin
            sck_reg   <= 1'b0;
            valid_reg <= 1'b1;
            last_reg  <= (conv_reg == len_reg);
            data_reg  <= data_next;
            ramp_reg  <= ramp_reg + 16'd1;
            state_reg <= S_GAP;
          end else begin
            sck_reg <= k_reg[0];
          end
        end

        S_GAP: begin
          if (t_reg == PERIOD_LAST) begin
            t_reg <= '0;
            if (conv_reg == len_reg) begin
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              conv_reg  <= conv_reg + 32'd1;
              cnv_reg   <= 1'b1;
              state_reg <= S_CNV;
            end
          end else begin
            t_reg <= t_reg + 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign adc_CNV        = cnv_reg;
  assign adc_SCK        = sck_reg;
  assign ctl.st_clr     = st_clr_reg;
  assign ctl.data       = data_reg;
  assign ctl.data_valid = valid_reg;
  assign ctl.data_last  = last_reg;
  assign ctl.busy       = busy_reg;

endmodule

// File: tb/tb_ltc2324_capture.sv
// Randomized scoreboard bench for ltc2324_capture: an ADC lane model feeds
// per-conversion words while monitors compare every valid word against queues.
module tb_ltc2324_capture;
  localparam int CH = 4;
  localparam int CW = 45;
  localparam int SP = 100;
  localparam int VALID_T = CH + CW + 32;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic adc_clk = 1'b0;
  logic adc_rst_n = 1'b0;
  always #5 adc_clk = ~adc_clk;

  logic adc_CNV, adc_SCK, t_CNV, t_SCK;
  logic sdo1 = 1'b0, sdo2 = 1'b0, sdo3 = 1'b0, sdo4 = 1'b0;

  ltc2324_capture_if ifm ();
  ltc2324_capture_if ift ();

  ltc2324_capture #(.CNV_HIGH_CYCLES(CH), .CONV_WAIT_CYCLES(CW),
                    .SAMPLE_PERIOD(SP), .TEST_MODE(1'b0)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .ctl(ifm),
    .adc_CNV(adc_CNV), .adc_SCK(adc_SCK),
    .adc_SDO1(sdo1), .adc_SDO2(sdo2), .adc_SDO3(sdo3), .adc_SDO4(sdo4)
  );

  ltc2324_capture #(.CNV_HIGH_CYCLES(CH), .CONV_WAIT_CYCLES(CW),
                    .SAMPLE_PERIOD(SP), .TEST_MODE(1'b1)) dut_t (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .ctl(ift),
    .adc_CNV(t_CNV), .adc_SCK(t_SCK),
    .adc_SDO1(sdo1), .adc_SDO2(sdo2), .adc_SDO3(sdo3), .adc_SDO4(sdo4)
  );

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  exp_t        exp_q[$];
  exp_t        tq[$];
  logic [63:0] lane_q[$];

  // ADC model: a new word per CNV rise, one bit per SCK rise, MSB first.
  logic [63:0] cur_word = '0;
  int          rise_n = 0;
  always @(posedge adc_CNV or posedge adc_SCK) begin
    if (adc_SCK) begin
      if (rise_n < 16) begin
        sdo1 = cur_word[63 - rise_n];
        sdo2 = cur_word[47 - rise_n];
        sdo3 = cur_word[31 - rise_n];
        sdo4 = cur_word[15 - rise_n];
      end
      rise_n++;
    end else begin
      rise_n = 0;
      cur_word = (lane_q.size() > 0) ? lane_q.pop_front() : 64'h0;
    end
  end

  int cyc = 0;
  int n_valid = 0, n_stclr = 0, n_cnv = 0, busy_cycles = 0, hold_err = 0;
  int cnv_rise_cyc = 0, cnv_w = 0, sck_cnt = 0, prev_valid_cyc = 0;
  logic in_burst = 1'b0, prev_cnv = 1'b0, prev_sck = 1'b0;
  logic [63:0] last_data = '0;
  exp_t mon_e;

  always @(negedge adc_clk) begin
    cyc++;
    if (!adc_rst_n) begin
      prev_cnv = 1'b0; prev_sck = 1'b0; cnv_w = 0; last_data = '0; in_burst = 1'b0;
    end else begin
      if (ifm.st_clr) n_stclr++;
      if (adc_CNV && !prev_cnv) begin
        n_cnv++; cnv_rise_cyc = cyc; sck_cnt = 0;
      end
      if (adc_CNV) cnv_w++;
      else if (prev_cnv) begin
        check("cnv_width", 64'(cnv_w), 64'(CH));
        cnv_w = 0;
      end
      if (adc_SCK && !prev_sck) sck_cnt++;
      if (ifm.busy) busy_cycles++;
      if (ifm.data_valid) begin
        n_valid++;
        $display("[%0d] valid #%0d data=%h last=%b", cyc, n_valid, ifm.data, ifm.data_last);
        if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("data", ifm.data, mon_e.data);
          check("last", 64'(ifm.data_last), 64'(mon_e.last));
        end
        check("valid_phase", 64'(cyc - cnv_rise_cyc), 64'(VALID_T));
        check("sck_pulses", 64'(sck_cnt), 64'd16);
        if (in_burst) check("valid_spacing", 64'(cyc - prev_valid_cyc), 64'(SP));
        in_burst = !ifm.data_last;
        prev_valid_cyc = cyc;
        last_data = ifm.data;
      end else if (ifm.data !== last_data) hold_err++;
      prev_cnv = adc_CNV;
      prev_sck = adc_SCK;
    end
  end

  int nt_valid = 0;
  exp_t mon_t;
  always @(negedge adc_clk) begin
    if (adc_rst_n && ift.data_valid) begin
      nt_valid++;
      $display("[%0d] test-mode valid #%0d data=%h last=%b", cyc, nt_valid, ift.data, ift.data_last);
      if (tq.size() == 0) check("tm_sb_underflow", 64'd1, 64'd0);
      else begin
        mon_t = tq.pop_front();
        check("tm_data", ift.data, mon_t.data);
        check("tm_last", 64'(ift.data_last), 64'(mon_t.last));
      end
    end
  end

  task automatic tick();
    @(negedge adc_clk);
    #1;
  endtask

  task automatic push_burst(int len, bit fixed);
    logic [63:0] w;
    for (int i = 0; i < len; i++) begin
      w = fixed ? 64'h0000_FFFF_0000_AAAA : {$urandom, $urandom};
      lane_q.push_back(w);
      exp_q.push_back('{data: w, last: (i == len - 1)});
    end
  endtask

  task automatic start_main(int len);
    int b;
    ifm.sample_len = len;
    ifm.sample_start = 1'b1;
    b = 0;
    do begin
      tick();
      b++;
    end while (!ifm.st_clr && b < 10);
    check("st_clr_seen", 64'(ifm.st_clr), 64'd1);
    check("cnv_with_st_clr", 64'(adc_CNV), 64'(len != 0));
    check("busy_with_st_clr", 64'(ifm.busy), 64'(len != 0));
    ifm.sample_start = 1'b0;
  endtask

  task automatic wait_valids(int target);
    int b;
    b = 0;
    while (n_valid < target && b < 3000) begin
      tick();
      b++;
    end
    check("valid_count", 64'(n_valid), 64'(target));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (ifm.busy && b < 500) begin
      tick();
      b++;
    end
    check("idle_reached", 64'(ifm.busy), 64'd0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_pins"}, 64'({adc_CNV, adc_SCK, t_CNV, t_SCK}), 64'd0);
    check({tag, "_ctl"}, 64'({ifm.st_clr, ifm.data_valid, ifm.data_last, ifm.busy}), 64'd0);
    check({tag, "_data"}, ifm.data, 64'd0);
  endtask

  int base_v, base_s, base_c, len_r, b;

  initial begin
    ifm.sample_start = 1'b0; ifm.sample_len = '0;
    ift.sample_start = 1'b0; ift.sample_len = '0;

    repeat (3) tick();
    check_all_zero("reset");
    adc_rst_n = 1'b1;
    repeat (10) tick();
    check("no_cnv_after_reset", 64'(n_cnv), 64'd0);

    // Fixed lane pattern, three conversions
    base_s = n_stclr; base_c = n_cnv; busy_cycles = 0;
    push_burst(3, 1'b1);
    start_main(3);
    wait_valids(3);
    wait_idle();
    check("fixed_st_clr", 64'(n_stclr - base_s), 64'd1);
    check("fixed_cnv", 64'(n_cnv - base_c), 64'd3);
    check("fixed_busy_cycles", 64'(busy_cycles), 64'(3 * SP));

    // Zero-length request: acknowledge only
    base_s = n_stclr; base_c = n_cnv; base_v = n_valid; busy_cycles = 0;
    start_main(0);
    repeat (150) tick();
    check("len0_st_clr", 64'(n_stclr - base_s), 64'd1);
    check("len0_cnv", 64'(n_cnv - base_c), 64'd0);
    check("len0_busy", 64'(busy_cycles), 64'd0);
    check("len0_valid", 64'(n_valid - base_v), 64'd0);

    // Random bursts
    for (int r = 0; r < 3; r++) begin
      len_r = $urandom_range(1, 4);
      base_v = n_valid;
      push_burst(len_r, 1'b0);
      start_main(len_r);
      wait_valids(base_v + len_r);
      wait_idle();
      repeat ($urandom_range(1, 5)) tick();
    end

    // Reset during SHIFT of conversion 2 of 3
    base_v = n_valid;
    push_burst(3, 1'b0);
    start_main(3);
    wait_valids(base_v + 1);
    repeat (78) @(posedge adc_clk);
    #2;
    check("sck_before_reset", 64'(adc_SCK), 64'd1);
    adc_rst_n = 1'b0;
    #1;
    check_all_zero("midshift_reset");
    repeat (3) tick();
    adc_rst_n = 1'b1;
    exp_q.delete();
    lane_q.delete();
    base_c = n_cnv;
    repeat (300) tick();
    check("no_valid_after_reset", 64'(n_valid), 64'(base_v + 1));
    check("no_cnv_until_start", 64'(n_cnv), 64'(base_c));
    base_v = n_valid;
    push_burst(3, 1'b0);
    start_main(3);
    wait_valids(base_v + 3);
    wait_idle();

    // sample_start held high, sample_len changed mid-burst
    base_v = n_valid; base_s = n_stclr;
    push_burst(2, 1'b0);
    push_burst(5, 1'b0);
    ifm.sample_len = 2;
    ifm.sample_start = 1'b1;
    wait_valids(base_v + 1);
    ifm.sample_len = 5;
    b = 0;
    while (n_stclr < base_s + 2 && b < 500) begin
      tick();
      b++;
    end
    ifm.sample_start = 1'b0;
    check("held_second_st_clr", 64'(n_stclr - base_s), 64'd2);
    wait_valids(base_v + 7);
    wait_idle();
    repeat (20) tick();
    check("held_total_st_clr", 64'(n_stclr - base_s), 64'd2);

    // Ramp words from the test-mode instance, two bursts
    for (int burst = 0; burst < 2; burst++) begin
      len_r = (burst == 0) ? 4 : 2;
      for (int i = 0; i < len_r; i++)
        tq.push_back('{data: {4{16'(i)}}, last: (i == len_r - 1)});
      ift.sample_len = len_r;
      ift.sample_start = 1'b1;
      b = 0;
      do begin
        tick();
        b++;
      end while (!ift.st_clr && b < 10);
      check("tm_st_clr", 64'(ift.st_clr), 64'd1);
      ift.sample_start = 1'b0;
      b = 0;
      while ((ift.busy || tq.size() > 0) && b < 1000) begin
        tick();
        b++;
      end
      check("tm_idle", 64'({ift.busy, 32'(tq.size())}), 64'd0);
    end
    check("tm_valid_total", 64'(nt_valid), 64'd6);

    check("data_hold", 64'(hold_err), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ltc2324_capture.md
# ltc2324_capture

Conversion sequencer and serial receiver for the LTC2324-16 quad ADC. On a start request it runs a burst of `sample_len` conversions. Each conversion drives CNV, waits out the conversion time, and clocks 16 bits from all four SDO lanes using an internally generated SCK. Each conversion yields one 64-bit word on a valid pulse. It sits directly upstream of the DMA packer/CDC FIFO in the `adc_clk` domain and owns the `sample_start`/`st_clr` handshake with software control.

## Interface
- `CNV_HIGH_CYCLES`, 4: adc_clk cycles CNV is held high per conversion (≥1).
- `CONV_WAIT_CYCLES`, 45: cycles from CNV falling to first SCK high (≥1).
- `SAMPLE_PERIOD`, 100: cycles per conversion; must be ≥ CNV_HIGH_CYCLES+CONV_WAIT_CYCLES+33.
- `TEST_MODE`, 1'b0: 1 = output words replaced by ramp pattern; pins still toggle.

Ports:
- `adc_clk` in 1: sole clock.
- `adc_rst_n` in 1: asynchronous, active-low reset.
- `sample_len` in 32: conversions per burst; latched at burst start.
- `sample_start` in 1: level start request from control.
- `st_clr` out 1: one-cycle pulse acknowledging start; control clears `sample_start` on it.
- `adc_CNV` out 1: conversion start to ADC.
- `adc_SCK` out 1: serial clock to ADC.
- `adc_SDO1`..`adc_SDO4` in 1 each: serial data lanes, MSB first.
- `data` out 64: {ch1, ch2, ch3, ch4}; ch1 in [63:48], ch4 in [15:0].
- `data_valid` out 1: one-cycle pulse, `data` valid.
- `data_last` out 1: high with `data_valid` on final conversion of burst.
- `busy` out 1: high from first CNV cycle until the burst returns to IDLE.

## Operation
- States: IDLE, CNV, WAIT, SHIFT, GAP. A period counter `t` counts 0..SAMPLE_PERIOD-1 per conversion. A burst counter is 32 bits.
- IDLE: when `sample_start`=1 at a clock edge, the block latches `sample_len` and pulses `st_clr` for the following cycle.
  - If the latched length is 0, it stays IDLE. No CNV, no valid.
  - Otherwise it enters CNV with t=0.
- CNV: `adc_CNV`=1 for t=0..CNV_HIGH_CYCLES-1, then WAIT.
- WAIT: `adc_CNV`=0, `adc_SCK`=0 until t=CNV_HIGH_CYCLES+CONV_WAIT_CYCLES-1, then SHIFT.
- SHIFT: 32 cycles k=0..31. `adc_SCK`=1 on even k and 0 on odd k. At the clock edge ending odd k, all four SDO lanes are shifted into their channel registers (bit 15-(k-1)/2).
- At the cycle after SHIFT ends, the block drives `data_valid`=1 and `data` updates in the same cycle. `data_last`=1 if this is conversion number `sample_len`. Then GAP.
- GAP: hold pins low until t=SAMPLE_PERIOD-1. Then either start the next CNV (t=0) or, after the final conversion, go to IDLE with `busy`=0.
- TEST_MODE=1: all four channel words equal a 16-bit ramp that starts at 0 on each burst start, increments after each valid, and wraps 0xFFFF→0.
- `sample_start` is not examined outside IDLE. A `sample_len` change mid-burst is ignored.
- If `sample_start` is still high when the block returns to IDLE, a new burst starts (back-to-back, at least one IDLE cycle).

## Timing
- Reset (async, any state, including mid-SHIFT) drives all of these to 0 immediately: `adc_CNV`, `adc_SCK`, `st_clr`, `data`, `data_valid`, `data_last`, `busy`. State returns to IDLE and the counters clear.
- Start latency: `sample_start` sampled at edge E. `st_clr`, `adc_CNV` and `busy` all go high in the cycle after E and coincide.
- `data_valid` occurs at t=CNV_HIGH_CYCLES+CONV_WAIT_CYCLES+32 of each period. Consecutive valids are exactly SAMPLE_PERIOD cycles apart.
- Burst duration is sample_len×SAMPLE_PERIOD cycles of `busy`.
- `data` holds its value between valids.

## Test plan
- Reset: assert `adc_rst_n`=0 mid-run → all outputs read 0 asynchronously. After release, no CNV until `sample_start`.
- Default params, `sample_len`=3, lane drive SDO1=0, SDO2=1, SDO3=0, SDO4 alternating 1,0 (MSB first) → the block produces:
  - one `st_clr` pulse;
  - 3 valids 100 cycles apart, each `data`=0x0000_FFFF_0000_AAAA;
  - `data_last` on the 3rd valid only;
  - 4 CNV pulses of width 4? No — exactly 3 CNV pulses of width 4, and 16 SCK pulses per conversion.
- `sample_len`=0 with `sample_start`=1 → one `st_clr` pulse, no CNV, `busy` stays 0, no `data_valid`.
- TEST_MODE=1, `sample_len`=4 → `data` = 0x0000_0000_0000_0000, 0x0001_0001_0001_0001, 0x0002…, 0x0003… in order, with `data_last` on the 4th valid.
- Reset asserted during SHIFT of conversion 2 of 3 → SCK/CNV low at once, no further valid. A restart after reset yields 3 fresh valids.
- `sample_start` held high (never cleared), `sample_len`=2, then changed to 5 mid-burst → the first burst yields 2 valids. A second burst of 5 valids follows with a second `st_clr` pulse.
